// File: rtl/fetch_pkg.sv
// Shared widths, buffer sizing, fetch state encoding and the address legality check.
package fetch_pkg;

    localparam int INSTR_W    = 32;
    localparam int ADDR_W     = 32;
    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = 2;
    localparam int PAYLOAD_W  = ADDR_W + INSTR_W;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // A fetch address is usable only when word aligned and inside the memory.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr,
                                        input logic [ADDR_W-1:0] last_addr);
        return (addr[1:0] == 2'b00) && (addr <= last_addr);
    endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry in-order buffer of {pc, instr}; push and pop may coincide, flush empties it.
module fetch_skid_fifo
    import fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [PAYLOAD_W-1:0]  push_data,
    output logic [PAYLOAD_W-1:0]  head_data,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [PAYLOAD_W-1:0]  entry_q [FIFO_DEPTH];
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [FIFO_CNT_W-1:0] count_q;

    // Storage, pointers and occupancy; flush wins over any push/pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push) begin
                entry_q[wr_ptr_q] <= push_data;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
        end
    end

    assign head_data = entry_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetcher over a 1-cycle-latency memory, with redirect and fault halt.
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | fetches issue whenever the output buffer has room
// HALT  | an illegal address was hit; nothing issues until a legal redirect
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter int                MEM_BYTES = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               fault,
    output logic [ADDR_W-1:0]  fault_pc
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 4);

    fetch_state_t          state_q, state_d;
    logic [ADDR_W-1:0]     fetch_pc_q, fetch_pc_d;
    logic                  pending_q, pending_d;
    logic [ADDR_W-1:0]     pending_pc_q, pending_pc_d;
    logic                  fault_q, fault_d;
    logic [ADDR_W-1:0]     fault_pc_q, fault_pc_d;

    logic                  issue;
    logic                  room;
    logic                  pop;
    logic                  push;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [PAYLOAD_W-1:0]  head_data;
    logic [2:0]            occupancy;

    assign mem_addr  = redirect_valid ? redirect_pc : fetch_pc_q;
    assign out_valid = (fifo_count != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    // The response in flight during a redirect belongs to the old stream.
    assign push      = pending_q && !redirect_valid;

    // Buffered plus in-flight entries, less the one leaving, must stay under the depth.
    assign occupancy = {1'b0, fifo_count} + {2'b00, pending_q};
    assign room      = occupancy < (3'd2 + {2'b00, pop});

    fetch_skid_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data ({pending_pc_q, mem_rdata}),
        .head_data (head_data),
        .count     (fifo_count)
    );

    assign {out_pc, out_instr} = head_data;
    assign fault               = fault_q;
    assign fault_pc            = fault_pc_q;

    // State and fetch bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            fetch_pc_q   <= RESET_PC;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
            fault_q      <= 1'b0;
            fault_pc_q   <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
            fault_q      <= fault_d;
            fault_pc_q   <= fault_pc_d;
        end
    end

    // Issue decision, halt on illegal addresses, resume on a legal redirect.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_d    = 1'b0;
        pending_pc_d = pending_pc_q;
        fault_d      = fault_q;
        fault_pc_d   = fault_pc_q;
        issue        = 1'b0;

        if (redirect_valid) begin
            // The flush empties the buffer, so a legal redirect always has room.
            if (addr_legal(redirect_pc, LAST_ADDR)) begin
                issue   = 1'b1;
                state_d = RUN;
                fault_d = 1'b0;
            end else begin
                state_d    = HALT;
                fault_d    = 1'b1;
                fault_pc_d = redirect_pc;
            end
        end else if (state_q == RUN && room) begin
            if (addr_legal(fetch_pc_q, LAST_ADDR)) begin
                issue = 1'b1;
            end else begin
                state_d    = HALT;
                fault_d    = 1'b1;
                fault_pc_d = fetch_pc_q;
            end
        end

        if (issue) begin
            pending_d    = 1'b1;
            pending_pc_d = mem_addr;
            fetch_pc_d   = mem_addr + 32'd4;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench: one default-sized fetch unit and one with a 16-byte memory.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fault_pc;

    logic        rst16_n;
    logic [31:0] mem_addr16;
    logic [31:0] mem_rdata16;
    logic        out_valid16;
    logic        out_ready16;
    logic [31:0] out_instr16;
    logic [31:0] out_pc16;
    logic        fault16;
    logic [31:0] fault_pc16;
    logic        redirect16_valid;
    logic [31:0] redirect16_pc;

    logic [31:0] mem_words [64];

    int checks;
    int errors;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    instr_fetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(16)) dut16 (
        .clk            (clk),
        .rst_n          (rst16_n),
        .mem_addr       (mem_addr16),
        .mem_rdata      (mem_rdata16),
        .redirect_valid (redirect16_valid),
        .redirect_pc    (redirect16_pc),
        .out_valid      (out_valid16),
        .out_ready      (out_ready16),
        .out_instr      (out_instr16),
        .out_pc         (out_pc16),
        .fault          (fault16),
        .fault_pc       (fault_pc16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency memory models; word at byte address a is A000_0000 | a/4.
    always @(posedge clk) begin
        mem_rdata   <= mem_words[mem_addr[7:2]];
        mem_rdata16 <= mem_words[mem_addr16[7:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Hold reset over two edges, check reset outputs, release; returns in cycle 0.
    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_fault_pc", fault_pc, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) begin
            mem_words[i] = 32'hA000_0000 | 32'(i);
        end
        rst_n            = 1'b0;
        rst16_n          = 1'b0;
        out_ready        = 1'b1;
        out_ready16      = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = 32'h0;
        redirect16_valid = 1'b0;
        redirect16_pc    = 32'h0;

        // Sequential stream with consumer always ready
        do_reset();
        #1;
        chk("a_c0_addr", mem_addr, 32'h0);
        chk("a_c0_valid", 32'(out_valid), 32'd0);
        cyc(); #1;
        chk("a_c1_addr", mem_addr, 32'h4);
        chk("a_c1_valid", 32'(out_valid), 32'd0);
        cyc(); #1;
        chk("a_c2_valid", 32'(out_valid), 32'd1);
        chk("a_c2_pc", out_pc, 32'h0);
        chk("a_c2_instr", out_instr, 32'hA000_0000);
        cyc(); #1;
        chk("a_c3_pc", out_pc, 32'h4);
        chk("a_c3_instr", out_instr, 32'hA000_0001);
        cyc(); #1;
        chk("a_c4_pc", out_pc, 32'h8);
        chk("a_c4_instr", out_instr, 32'hA000_0002);
        cyc(); #1;
        chk("a_c5_valid", 32'(out_valid), 32'd1);
        chk("a_c5_pc", out_pc, 32'hC);
        chk("a_c5_instr", out_instr, 32'hA000_0003);

        // Consumer stalls for 5 cycles after first valid
        do_reset();
        cyc();
        cyc(); out_ready = 1'b0; #1;
        chk("b_c2_pc", out_pc, 32'h0);
        chk("b_c2_valid", 32'(out_valid), 32'd1);
        cyc(); #1;
        chk("b_c3_pc", out_pc, 32'h0);
        chk("b_c3_addr", mem_addr, 32'h8);
        cyc(); #1;
        chk("b_c4_count", 32'(dut.fifo_count), 32'd2);
        chk("b_c4_pc", out_pc, 32'h0);
        chk("b_c4_addr", mem_addr, 32'h8);
        cyc(); #1;
        chk("b_c5_addr", mem_addr, 32'h8);
        cyc(); #1;
        chk("b_c6_pc", out_pc, 32'h0);
        chk("b_c6_addr", mem_addr, 32'h8);
        cyc(); out_ready = 1'b1; #1;
        chk("b_c7_pc", out_pc, 32'h0);
        chk("b_c7_instr", out_instr, 32'hA000_0000);
        cyc(); #1;
        chk("b_c8_pc", out_pc, 32'h4);
        chk("b_c8_valid", 32'(out_valid), 32'd1);
        cyc(); #1;
        chk("b_c9_pc", out_pc, 32'h8);
        chk("b_c9_valid", 32'(out_valid), 32'd1);
        cyc(); #1;
        chk("b_c10_pc", out_pc, 32'hC);
        chk("b_c10_instr", out_instr, 32'hA000_0003);

        // Redirect to 0x40 while 8 and 12 are buffered and the head is stalled
        do_reset();
        cyc();
        cyc(); #1;
        chk("c_c2_pc", out_pc, 32'h0);
        cyc(); #1;
        chk("c_c3_pc", out_pc, 32'h4);
        cyc(); out_ready = 1'b0; #1;
        chk("c_c4_pc", out_pc, 32'h8);
        cyc(); #1;
        chk("c_c5_count", 32'(dut.fifo_count), 32'd2);
        chk("c_c5_pc", out_pc, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        #1;
        chk("c_c5_valid", 32'(out_valid), 32'd0);
        chk("c_c5_addr", mem_addr, 32'h40);
        cyc(); redirect_valid = 1'b0; out_ready = 1'b1; #1;
        chk("c_c6_valid", 32'(out_valid), 32'd0);
        cyc(); #1;
        chk("c_c7_valid", 32'(out_valid), 32'd1);
        chk("c_c7_pc", out_pc, 32'h40);
        chk("c_c7_instr", out_instr, 32'hA000_0010);
        cyc(); #1;
        chk("c_c8_pc", out_pc, 32'h44);
        chk("c_c8_instr", out_instr, 32'hA000_0011);

        // Misaligned redirect faults, legal redirect recovers
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h42; #1;
        chk("d_c9_valid", 32'(out_valid), 32'd0);
        cyc(); redirect_valid = 1'b0; #1;
        chk("d_c10_fault", 32'(fault), 32'd1);
        chk("d_c10_fault_pc", fault_pc, 32'h42);
        chk("d_c10_valid", 32'(out_valid), 32'd0);
        cyc(); #1;
        chk("d_c11_valid", 32'(out_valid), 32'd0);
        chk("d_c11_addr", mem_addr, 32'h50);
        cyc(); #1;
        chk("d_c12_valid", 32'(out_valid), 32'd0);
        chk("d_c12_addr", mem_addr, 32'h50);
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h10; #1;
        chk("d_c13_addr", mem_addr, 32'h10);
        cyc(); redirect_valid = 1'b0; #1;
        chk("d_c14_fault", 32'(fault), 32'd0);
        chk("d_c14_valid", 32'(out_valid), 32'd0);
        cyc(); #1;
        chk("d_c15_valid", 32'(out_valid), 32'd1);
        chk("d_c15_pc", out_pc, 32'h10);
        chk("d_c15_instr", out_instr, 32'hA000_0004);

        // 16-byte memory: run off the end, then reset mid-stream
        cyc(); rst16_n = 1'b1; #1;
        chk("e_c0_addr", mem_addr16, 32'h0);
        cyc();
        cyc(); #1;
        chk("e_c2_pc", out_pc16, 32'h0);
        chk("e_c2_valid", 32'(out_valid16), 32'd1);
        cyc(); #1;
        chk("e_c3_pc", out_pc16, 32'h4);
        cyc(); #1;
        chk("e_c4_pc", out_pc16, 32'h8);
        chk("e_c4_fault", 32'(fault16), 32'd0);
        cyc(); #1;
        chk("e_c5_pc", out_pc16, 32'hC);
        chk("e_c5_instr", out_instr16, 32'hA000_0003);
        chk("e_c5_fault", 32'(fault16), 32'd1);
        chk("e_c5_fault_pc", fault_pc16, 32'h10);
        cyc(); #1;
        chk("e_c6_valid", 32'(out_valid16), 32'd0);
        chk("e_c6_fault", 32'(fault16), 32'd1);

        rst16_n = 1'b0;
        cyc(); rst16_n = 1'b1; #1;
        chk("f_c0_addr", mem_addr16, 32'h0);
        chk("f_c0_fault", 32'(fault16), 32'd0);
        cyc();
        cyc(); #1;
        chk("f_c2_pc", out_pc16, 32'h0);
        cyc(); #1;
        chk("f_c3_pc", out_pc16, 32'h4);
        chk("f_c3_valid", 32'(out_valid16), 32'd1);
        rst16_n = 1'b0;
        #1;
        chk("f_async_valid", 32'(out_valid16), 32'd0);
        chk("f_async_pc", out_pc16, 32'h0);
        cyc(); rst16_n = 1'b1; #1;
        chk("g_c0_addr", mem_addr16, 32'h0);
        chk("g_c0_valid", 32'(out_valid16), 32'd0);
        cyc();
        cyc(); #1;
        chk("g_c2_pc", out_pc16, 32'h0);
        chk("g_c2_instr", out_instr16, 32'hA000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter MEM_BYTES, default 256: instruction memory size in bytes; legal fetch addresses are 0..MEM_BYTES-4.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 mem_addr  out  32  byte address to instruction memory (sampled by memory each rising edge).
REQ-006 mem_rdata  in  32  big-endian word from memory, valid the cycle after its address was sampled.
REQ-007 redirect_valid  in  1  one-cycle request to restart fetch at redirect_pc.
REQ-008 redirect_pc  in  32  redirect target byte address.
REQ-009 out_valid  out  1  out_instr/out_pc hold a fetched instruction.
REQ-010 out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
REQ-011 out_instr  out  32  fetched instruction word.
REQ-012 out_pc  out  32  byte address of out_instr.
REQ-013 fault  out  1  fetch halted on an illegal address.
REQ-014 fault_pc  out  32  illegal address that caused the halt.

Function
REQ-015 States RUN and HALT; RUN issues fetches, HALT issues none.
REQ-016 Memory has fixed 1-cycle latency; an address issued in cycle t returns on mem_rdata in cycle t+1, captured at the end of t+1.
REQ-017 mem_addr = redirect_pc when redirect_valid, else fetch_pc register.
REQ-018 A fetch issues in cycle t iff state==RUN (or redirect to a legal target) and (fifo_count + pending - pop) < 2, where pop = out_valid && out_ready.
REQ-019 On issue: pending<=1, pending_pc<=issued address, fetch_pc<=issued address+4 (mod 2^32); otherwise pending<=0.
REQ-020 When pending==1, mem_rdata and pending_pc are pushed into the 2-entry output FIFO; unissued cycles' rdata is ignored.
REQ-021 Output FIFO in order; out_valid = (fifo_count!=0) && !redirect_valid; out_instr/out_pc from head, stable while out_valid && !out_ready.
REQ-022 Push and pop in the same cycle are both honoured; FIFO never overflows (guaranteed by REQ-018).
REQ-023 Steady-state throughput with out_ready held high: one instruction per cycle.
REQ-024 Redirect: FIFO flushed, in-flight response discarded, no transfer that cycle, new fetch at redirect_pc issued that same cycle.
REQ-025 Redirect target legal = low 2 bits zero and <= MEM_BYTES-4; illegal target: no issue, flush, state<=HALT, fault<=1, fault_pc<=redirect_pc.
REQ-026 Sequential fetch_pc illegal at issue time: no issue, state<=HALT, fault<=1, fault_pc<=fetch_pc; existing FIFO entries and pending response still delivered.
REQ-027 Redirect to a legal target while in HALT: state<=RUN, fault<=0, fetch issued that cycle.
REQ-028 Redirect while out_ready stalled: flush takes priority; stalled head is dropped.

Reset
REQ-029 While rst_n==0: state=RUN, fetch_pc=RESET_PC, pending=0, fifo_count=0, out_valid=0, fault=0, fault_pc=0; out_instr/out_pc=0.
REQ-030 First fetch issues in the first cycle after rst_n deasserts; out_valid rises after the second rising edge.
REQ-031 Reset asserted mid-operation discards all pending and buffered instructions immediately.

Structure
REQ-032 Shared package fetch_pkg holds INSTR_W=32, ADDR_W=32, FIFO depth 2, state enum {RUN, HALT}.
REQ-033 Output buffer is sub-module fetch_skid_fifo (2-entry, 64-bit payload {pc, instr}, push/pop/flush, count).

Verification
REQ-034 Reset release, out_ready=1, memory holds words W0..W3 at 0,4,8,12 -> out_valid from cycle 2, out_pc 0,4,8,12 consecutive cycles with matching instr.
REQ-035 out_ready=0 for 5 cycles after first valid -> exactly 2 entries buffered, mem fetch stops, out_pc=0 held; release -> 0,4,8 with no loss or duplicate.
REQ-036 Redirect to 0x40 while FIFO holds pc 8,12 -> out_valid=0 that cycle, next delivered out_pc=0x40 then 0x44; 8/12 never delivered.
REQ-037 Redirect to 0x42 -> fault=1, fault_pc=0x42, out_valid=0, no further fetches; redirect to 0x10 -> fault=0, out_pc=0x10 delivered.
REQ-038 MEM_BYTES=16, run sequentially -> pcs 0,4,8,12 delivered, then fault=1, fault_pc=16; rst_n pulsed mid-stream -> out_valid=0 immediately, restart at RESET_PC.
